// File: rtl/sll32_seq.sv
// sll32_seq: multi-cycle 32-bit logical shift-left unit.
// A start request in IDLE latches A and B[4:0]. The operand is then shifted left by up to
// STEP bits per cycle, zero-filling from the LSB. A one-cycle done pulse marks the result.
// res only changes when the result is loaded on entry to DONE, so it stays stable for the consumer.
// Optional feature: define SLL32_OVF_EN to add the sticky overflow output ovf.
module sll32_seq #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] res
`ifdef SLL32_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // STEP is restricted to 1..32, so it always fits in six bits.
  localparam logic [5:0] STEP_AMT = 6'(STEP);

  logic [1:0]  state;
  logic [31:0] acc;
  logic [4:0]  rem;
  logic [5:0]  step_k;
  logic [4:0]  rem_next;
  logic [31:0] shifted;
  logic        unused_b;

  // Only the low five bits of B form the shift amount.
  assign unused_b = ^B[31:5];

  // Shift by a full STEP, or by whatever is left when the remaining amount is smaller.
  always_comb begin
    step_k   = ({1'b0, rem} >= STEP_AMT) ? STEP_AMT : {1'b0, rem};
    rem_next = rem - step_k[4:0];
  end

`ifdef SLL32_OVF_EN
  logic [63:0] wide;
  logic        lost;

  // The upper half of the widened shift holds the bits pushed out past bit 31.
  always_comb begin
    wide    = {32'b0, acc} << step_k;
    shifted = wide[31:0];
    lost    = |wide[63:32];
  end
`else
  // Shift the accumulator by this cycle's step.
  always_comb begin
    shifted = acc << step_k;
  end
`endif

  // Control FSM together with the datapath registers and the registered busy/done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= 32'd0;
      rem   <= 5'd0;
      res   <= 32'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SLL32_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc  <= A;
            rem  <= B[4:0];
            busy <= 1'b1;
`ifdef SLL32_OVF_EN
            ovf  <= 1'b0;
`endif
            if (B[4:0] == 5'd0) begin
              state <= S_DONE;
              res   <= A;
              done  <= 1'b1;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc <= shifted;
          rem <= rem_next;
`ifdef SLL32_OVF_EN
          ovf <= ovf | lost;
`endif
          if (rem_next == 5'd0) begin
            state <= S_DONE;
            res   <= shifted;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sll32_seq.sv
// tb_sll32_seq: scoreboard bench for sll32_seq.
// The stimulus side predicts, from the shift rules and the latency formula, which requests
// are accepted and what each should produce. A monitor pops those predictions on done.
// Define SLL32_OVF_EN to also exercise the overflow output.
module tb_sll32_seq;

  localparam int STEP = 1;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          done_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] res;
`ifdef SLL32_OVF_EN
  logic        ovf;
`endif

  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  int          next_free = 0;
  int          busy_from = -1;
  int          busy_to = -2;
  logic [31:0] last_res = 32'd0;
  exp_t        q[$];

  sll32_seq #(.STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .start (start),
    .busy  (busy),
    .done  (done),
    .res   (res)
`ifdef SLL32_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Free-running clock and a count of rising edges seen so far.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference behaviour: plain shift arithmetic plus the documented latency.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int e);
    exp_t m;
    int   sh;
    int   lat;
    sh  = int'(b[4:0]);
    m.res = a << sh;
    m.ovf = (sh != 0) && ((a >> (32 - sh)) != 32'd0);
    lat = (sh + STEP - 1) / STEP + 1;
    m.done_edge = e + lat - 1;
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs (called at a falling edge) and record any request the DUT must accept.
  task automatic apply_stimulus(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t m;
    start = s;
    A     = a;
    B     = b;
    if (s && rst_n && (cyc + 1 >= next_free)) begin
      m = model(a, b, cyc + 1);
      q.push_back(m);
      busy_from = cyc + 1;
      busy_to   = m.done_edge;
      next_free = m.done_edge + 2;
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    while (cyc + 1 < next_free) apply_stimulus(1'b0, $urandom, $urandom);
  endtask

  // Monitor: compare on every done pulse, and check res hold and busy in all other cycles.
  always @(negedge clk) begin : monitor
    exp_t m;
    logic exp_busy;
    exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
    check("busy", {31'd0, busy}, {31'd0, exp_busy});
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: got done=1 res=%h, expected no done (edge %0d)", res, cyc);
      end else begin
        m = q.pop_front();
        check("res", res, m.res);
        check("done_edge", cyc, m.done_edge);
`ifdef SLL32_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, m.ovf});
`endif
        last_res = m.res;
      end
    end else begin
      check("res_hold", res, last_res);
      if (q.size() != 0 && cyc > q[0].done_edge) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL missing_done: got done=0, expected done at edge %0d (now %0d)",
                 q[0].done_edge, cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin : stim
    logic [31:0] a;
    logic [31:0] b;
    int          r;

    // Reset held with start asserted.
    rst_n = 1'b0;
    start = 1'b1;
    A     = $urandom;
    B     = $urandom;
    repeat (3) @(negedge clk);
    check("reset_res", res, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_res", res, 32'd0);
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    // Directed cases.
    wait_idle(); apply_stimulus(1'b1, 32'h7FFF_FFFF, 32'd1);
    wait_idle(); apply_stimulus(1'b1, 32'h0000_0001, 32'd31);
    wait_idle(); apply_stimulus(1'b1, 32'h1234_5678, 32'h0000_0040);
    wait_idle(); apply_stimulus(1'b1, 32'h0000_00FF, 32'd4);
    apply_stimulus(1'b1, 32'hFFFF_FFFF, 32'd3);
    wait_idle(); apply_stimulus(1'b1, 32'h8000_0001, 32'd1);
    wait_idle(); apply_stimulus(1'b1, 32'h0000_0001, 32'd1);

    // Randomized traffic with start often held high, including during busy.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 5);
      a = $urandom;
      b = (r == 0) ? 32'd0 : (r == 1) ? 32'd31 : $urandom;
      apply_stimulus($urandom_range(0, 3) != 0, a, b);
    end

    // Abort mid-operation on the fifth SHIFT cycle.
    wait_idle();
    apply_stimulus(1'b1, 32'h0000_0001, 32'd20);
    repeat (4) apply_stimulus(1'b0, $urandom, $urandom);
    #2;
    rst_n     = 1'b0;
    q.delete();
    last_res  = 32'd0;
    busy_to   = -2;
    next_free = 0;
    #1;
    check("abort_res", res, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
`ifdef SLL32_OVF_EN
    check("abort_ovf", {31'd0, ovf}, 32'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) apply_stimulus(1'b0, $urandom, $urandom);

    // A final request after the abort, then drain the scoreboard.
    wait_idle(); apply_stimulus(1'b1, 32'hDEAD_BEEF, 32'd8);
    for (int i = 0; i < 100 && q.size() != 0; i++) apply_stimulus(1'b0, $urandom, $urandom);
    if (q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("[TB] FAIL drain: got %0d outstanding results, expected 0", q.size());
    end
    repeat (3) apply_stimulus(1'b0, $urandom, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
